cpm_rst_seq: RTL and testbench
==============================

# cpm_rst_seq

Synthesizable reset and bring-up sequencer for one CPM5 PCIe controller pair (QDMA endpoint or root-port side). It orders POR, the CPM5 LPD POR, PERST#, and PL fabric reset release, then waits for link-up under a bounded timeout with retry. It replaces hand-ordered reset forcing in the simulation board for these signals, and the same RTL ships in the hardware design.

## Interface
Parameters:
- POR_HOLD_CYC, default 500: cycles all resets are held asserted after a sequence starts.
- PERST_DELAY_CYC, default 100: cycles from POR release to PERST# release.
- LINKUP_TIMEOUT_CYC, default 65536: maximum cycles to wait in LINK_WAIT.
- MAX_RETRY, default 3: total bring-up attempts before FAIL (minimum 1).
- PL_RST_W, default 4: number of PL reset outputs.

Ports:
- sys_clk  in  1  sequencer clock, single clock domain.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin (or restart from FAIL) the sequence.
- link_up  in  1  asynchronous link-up status from the CPM; synchronized internally.
- por_n  out  1  PS POR release, active-low.
- cpm_por_n  out  1  CPM5 LPD POR release, active-low.
- perst_n  out  2  PERST0N/PERST1N, active-low.
- pl_rst_n  out  PL_RST_W  PL output resets, active-low.
- done  out  1  link is up and the sequence is complete.
- fail  out  1  all retries are exhausted.
- retry_cnt  out  $clog2(MAX_RETRY+1)  number of failed attempts in the current run.
- state_o  out  3  current FSM state encoding, for debug.

## Operation
- The FSM has states IDLE(0), POR_HOLD(1), PERST_WAIT(2), PL_REL(3), LINK_WAIT(4), UP(5), FAIL(6).
- All outputs are registered. Reset values: por_n=0, cpm_por_n=0, perst_n=2'b00, pl_rst_n=0, done=0, fail=0, retry_cnt=0, state IDLE.
- IDLE: all resets stay asserted. start=1 moves the FSM to POR_HOLD and clears the cycle counter.
- POR_HOLD: counts POR_HOLD_CYC cycles, then releases por_n and cpm_por_n in the same cycle and enters PERST_WAIT.
- PERST_WAIT: counts PERST_DELAY_CYC cycles, then releases both perst_n bits together and enters PL_REL.
- PL_REL: lasts one cycle, releases all pl_rst_n bits, then enters LINK_WAIT.
- LINK_WAIT: if synchronized link_up=1, enter UP, set done=1, and clear retry_cnt. If the counter reaches LINKUP_TIMEOUT_CYC first, increment retry_cnt and reassert every reset output in the next cycle:
  - if retry_cnt+1 == MAX_RETRY, enter FAIL with fail=1;
  - otherwise, enter POR_HOLD.
- UP: holds. Link-down handling is set by the Configuration section.
- FAIL: all resets are asserted and fail=1. start clears fail and retry_cnt and enters POR_HOLD.
- start is ignored in every state except IDLE and FAIL.
- Counters are sized to $clog2 of the largest cycle parameter plus 1. They clear on every state entry and never wrap.
- Asserting sys_rst_n mid-sequence returns all outputs to their reset values immediately (asynchronously).

## Timing
- Let edge 0 be the edge that samples start=1.
- por_n and cpm_por_n rise at edge POR_HOLD_CYC+1.
- perst_n rises PERST_DELAY_CYC edges after por_n.
- pl_rst_n rises 1 edge after perst_n.
- link_up passes through a 2-flop synchronizer. done rises on the 3rd edge after link_up goes high, provided the FSM is in LINK_WAIT.
- If link_up is already high on entry to LINK_WAIT, UP follows after the synchronizer delay.
- If the timeout and link_up occur in the same cycle, link_up wins.

## Configuration
- CPM_RST_SEQ_LINKDOWN_RECOVER_EN defined:
  - in UP, synchronized link_up=0 for one cycle clears done, reasserts perst_n and pl_rst_n (POR stays released), and enters PERST_WAIT;
  - this recovery does not increment retry_cnt.
- Macro not defined: UP is terminal until sys_rst_n; done stays 1 regardless of link_up.

## Structure
- cpm_rst_seq_pkg holds the state enum typedef (3-bit), its encodings, and the PL_RST_W default.
- One sub-module, cpm_rst_sync2, is the 2-flop link_up synchronizer with asynchronous active-low reset to 0.
- Everything else lives in a single FSM plus counter process.

## Test plan
All scenarios use POR_HOLD_CYC=8, PERST_DELAY_CYC=4, LINKUP_TIMEOUT_CYC=16, MAX_RETRY=2.
- Nominal: start at edge 0, link_up high at edge 20 -> por_n rises at 9, perst_n at 13, pl_rst_n at 14, done=1 at 23, retry_cnt=0.
- Single retry: link_up held low, then high at edge 40 -> first timeout reasserts all resets at edge 31 with retry_cnt=1; second attempt reaches UP with done=1 and retry_cnt=0.
- Exhaustion: link_up always 0 -> fail=1 after two timeouts with all resets asserted; start then clears fail and restarts, so por_n rises 9 edges later.
- Reset mid-sequence: sys_rst_n pulsed low in PERST_WAIT -> all outputs return to reset values immediately and state_o=0.
- Link-down with macro: in UP, link_up drops -> done=0 and perst_n=00 within 3 edges, por_n stays 1, and done returns after relink. Without the macro: done stays 1.
- Ignored start: start pulsed in LINK_WAIT -> no state change and counter undisturbed.

Source files
------------

// File: rtl/cpm_rst_seq_pkg.sv
// Shared types and defaults for the CPM5 reset/bring-up sequencer.
// The optional macro CPM_RST_SEQ_LINKDOWN_RECOVER_EN is consumed by cpm_rst_seq.sv.
package cpm_rst_seq_pkg;

  // FSM state encodings, also exported on state_o for debug
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_POR_HOLD   = 3'd1,
    ST_PERST_WAIT = 3'd2,
    ST_PL_REL     = 3'd3,
    ST_LINK_WAIT  = 3'd4,
    ST_UP         = 3'd5,
    ST_FAIL       = 3'd6
  } state_t;

  localparam int unsigned PL_RST_W_DEF = 4;

  // Largest of three cycle parameters, used to size the shared counter
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/cpm_rst_sync2.sv
// Two-flop synchronizer for the asynchronous CPM link_up status.
module cpm_rst_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture, cleared to 0 by the asynchronous reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/cpm_rst_seq.sv
// Reset and bring-up sequencer for one CPM5 PCIe controller pair.
// Orders POR / CPM LPD POR / PERST# / PL reset release, then waits for
// link-up with a bounded timeout and retry.
// Optional: define CPM_RST_SEQ_LINKDOWN_RECOVER_EN to re-run PERST#/PL
// release when the link drops while UP; otherwise UP is terminal.
module cpm_rst_seq
  import cpm_rst_seq_pkg::*;
#(
  parameter int unsigned POR_HOLD_CYC       = 500,
  parameter int unsigned PERST_DELAY_CYC    = 100,
  parameter int unsigned LINKUP_TIMEOUT_CYC = 65536,
  parameter int unsigned MAX_RETRY          = 3,
  parameter int unsigned PL_RST_W           = PL_RST_W_DEF
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic                             start,
  input  logic                             link_up,
  output logic                             por_n,
  output logic                             cpm_por_n,
  output logic [1:0]                       perst_n,
  output logic [PL_RST_W-1:0]              pl_rst_n,
  output logic                             done,
  output logic                             fail,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
  output logic [2:0]                       state_o
);

  localparam int unsigned RW    = $clog2(MAX_RETRY + 1);
  localparam int unsigned CNT_W =
    $clog2(max3(POR_HOLD_CYC, PERST_DELAY_CYC, LINKUP_TIMEOUT_CYC)) + 1;

  // Terminal counts. PERST_WAIT exits one count earlier than POR_HOLD so
  // that perst_n rises exactly PERST_DELAY_CYC edges after por_n.
  localparam logic [CNT_W-1:0] C_POR   = CNT_W'(POR_HOLD_CYC);
  localparam logic [CNT_W-1:0] C_PERST =
    CNT_W'((PERST_DELAY_CYC == 0) ? 0 : PERST_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] C_TO    = CNT_W'(LINKUP_TIMEOUT_CYC);
  localparam logic [RW-1:0]    C_LAST  = RW'(MAX_RETRY - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_por_n;
  logic                 r_cpm_por_n;
  logic [1:0]           r_perst_n;
  logic [PL_RST_W-1:0]  r_pl_rst_n;
  logic                 r_done;
  logic                 r_fail;
  logic [RW-1:0]        r_retry_cnt;
  logic                 w_link_sync;

  cpm_rst_sync2 u_link_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (link_up),
    .o_q     (w_link_sync)
  );

  // Sequencer FSM with its cycle counter and all registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_por_n     <= 1'b0;
      r_cpm_por_n <= 1'b0;
      r_perst_n   <= '0;
      r_pl_rst_n  <= '0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_POR_HOLD;
            r_cnt   <= '0;
          end
        end
        ST_POR_HOLD: begin
          if (r_cnt == C_POR) begin
            r_por_n     <= 1'b1;
            r_cpm_por_n <= 1'b1;
            r_state     <= ST_PERST_WAIT;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PERST_WAIT: begin
          if (r_cnt == C_PERST) begin
            r_perst_n <= '1;
            r_state   <= ST_PL_REL;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PL_REL: begin
          r_pl_rst_n <= '1;
          r_state    <= ST_LINK_WAIT;
          r_cnt      <= '0;
        end
        ST_LINK_WAIT: begin
          // link_up is tested first so it wins over a coincident timeout
          if (w_link_sync) begin
            r_done      <= 1'b1;
            r_retry_cnt <= '0;
            r_state     <= ST_UP;
            r_cnt       <= '0;
          end else if (r_cnt == C_TO) begin
            r_retry_cnt <= r_retry_cnt + RW'(1);
            r_por_n     <= 1'b0;
            r_cpm_por_n <= 1'b0;
            r_perst_n   <= '0;
            r_pl_rst_n  <= '0;
            r_cnt       <= '0;
            if (r_retry_cnt == C_LAST) begin
              r_fail  <= 1'b1;
              r_state <= ST_FAIL;
            end else begin
              r_state <= ST_POR_HOLD;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_UP: begin
`ifdef CPM_RST_SEQ_LINKDOWN_RECOVER_EN
          if (!w_link_sync) begin
            r_done     <= 1'b0;
            r_perst_n  <= '0;
            r_pl_rst_n <= '0;
            r_state    <= ST_PERST_WAIT;
            r_cnt      <= '0;
          end
`else
          r_done <= 1'b1;
`endif
        end
        ST_FAIL: begin
          if (start) begin
            r_fail      <= 1'b0;
            r_retry_cnt <= '0;
            r_state     <= ST_POR_HOLD;
            r_cnt       <= '0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_por_n     <= 1'b0;
          r_cpm_por_n <= 1'b0;
          r_perst_n   <= '0;
          r_pl_rst_n  <= '0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign por_n     = r_por_n;
  assign cpm_por_n = r_cpm_por_n;
  assign perst_n   = r_perst_n;
  assign pl_rst_n  = r_pl_rst_n;
  assign done      = r_done;
  assign fail      = r_fail;
  assign retry_cnt = r_retry_cnt;
  assign state_o   = r_state;

endmodule

// File: tb/tb_cpm_rst_seq.sv
// Self-checking bench for cpm_rst_seq using an edge-indexed scoreboard.
module tb_cpm_rst_seq;

  localparam int PL_W = 4;

  logic            clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            start = 1'b0;
  logic            link_up = 1'b0;
  logic            por_n, cpm_por_n, done, fail;
  logic [1:0]      perst_n;
  logic [PL_W-1:0] pl_rst_n;
  logic [1:0]      retry_cnt;
  logic [2:0]      state_o;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef enum int {S_POR, S_CPM, S_PERST, S_PL, S_DONE, S_FAIL, S_RETRY, S_STATE} sig_e;
  typedef struct { int edge_n; sig_e sig; int val; } exp_t;
  exp_t sbq[$];

  cpm_rst_seq #(
    .POR_HOLD_CYC       (8),
    .PERST_DELAY_CYC    (4),
    .LINKUP_TIMEOUT_CYC (16),
    .MAX_RETRY          (2),
    .PL_RST_W           (PL_W)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .link_up   (link_up),
    .por_n     (por_n),
    .cpm_por_n (cpm_por_n),
    .perst_n   (perst_n),
    .pl_rst_n  (pl_rst_n),
    .done      (done),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_POR:   return {31'd0, por_n};
      S_CPM:   return {31'd0, cpm_por_n};
      S_PERST: return {30'd0, perst_n};
      S_PL:    return {28'd0, pl_rst_n};
      S_DONE:  return {31'd0, done};
      S_FAIL:  return {31'd0, fail};
      S_RETRY: return {30'd0, retry_cnt};
      default: return {29'd0, state_o};
    endcase
  endfunction

  task automatic push(input int e, input sig_e s, input int v);
    exp_t x;
    x.edge_n = e; x.sig = s; x.val = v;
    sbq.push_back(x);
  endtask

  // One clock edge; pop and compare every expectation due at this edge
  task automatic step();
    exp_t x;
    logic [31:0] obs;
    @(posedge clk);
    cyc++;
    #1;
    while (sbq.size() > 0 && sbq[0].edge_n <= cyc) begin
      x = sbq.pop_front();
      obs = observe(x.sig);
      n_vec++;
      if (obs !== 32'(x.val)) begin
        n_bad++;
        $display("FAIL %s @edge%0d: got %0d expected %0d", x.sig.name(), x.edge_n, obs, x.val);
      end
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic start_seq();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cyc = 0;
    #1;
    start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    sys_rst_n = 1'b0;
    start = 1'b0;
    link_up = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic check_all_reset(input string tag);
    n_vec++;
    if ({por_n, cpm_por_n, perst_n, pl_rst_n, done, fail, retry_cnt, state_o} !== '0) begin
      n_bad++;
      $display("FAIL %s: got por=%b cpm=%b perst=%b pl=%b done=%b fail=%b retry=%0d st=%0d expected all 0",
               tag, por_n, cpm_por_n, perst_n, pl_rst_n, done, fail, retry_cnt, state_o);
    end
  endtask

  task automatic flush_check(input string tag);
    if (sbq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: %0d expectations left unchecked, expected 0", tag, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_reset("reset_values");
    sys_rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    apply_reset();
    start_seq();
    push(1, S_STATE, 1);
    push(8, S_POR, 0);   push(8, S_STATE, 1);
    push(9, S_POR, 1);   push(9, S_CPM, 1);   push(9, S_PERST, 0); push(9, S_STATE, 2);
    push(12, S_PERST, 0);
    push(13, S_PERST, 3); push(13, S_PL, 0);  push(13, S_STATE, 3);
    push(14, S_PL, 15);  push(14, S_STATE, 4);
    push(20, S_DONE, 0);
    run_to(20);
    link_up = 1'b1;
    push(22, S_DONE, 0);
    push(23, S_DONE, 1); push(23, S_STATE, 5); push(23, S_RETRY, 0);
    run_to(23);
    flush_check("nominal");
  endtask

  // Continues from UP at edge 23 of test_nominal
  task automatic test_linkdown();
    link_up = 1'b0;
    push(25, S_DONE, 1);
`ifdef CPM_RST_SEQ_LINKDOWN_RECOVER_EN
    push(26, S_DONE, 0); push(26, S_PERST, 0); push(26, S_POR, 1);
    push(26, S_PL, 0);   push(26, S_STATE, 2); push(26, S_RETRY, 0);
    run_to(26);
    link_up = 1'b1;
    push(30, S_PERST, 3);
    push(31, S_PL, 15);  push(31, S_STATE, 4);
    push(32, S_DONE, 1); push(32, S_STATE, 5);
`else
    push(26, S_DONE, 1); push(26, S_STATE, 5); push(26, S_PERST, 3); push(26, S_POR, 1);
    run_to(26);
    link_up = 1'b1;
    push(32, S_DONE, 1); push(32, S_STATE, 5);
`endif
    run_to(32);
    flush_check("linkdown");
  endtask

  task automatic test_single_retry();
    apply_reset();
    start_seq();
    push(30, S_STATE, 4); push(30, S_POR, 1); push(30, S_RETRY, 0);
    push(31, S_POR, 0);   push(31, S_CPM, 0); push(31, S_PERST, 0); push(31, S_PL, 0);
    push(31, S_RETRY, 1); push(31, S_STATE, 1); push(31, S_DONE, 0);
    push(39, S_POR, 0);
    push(40, S_POR, 1);
    run_to(40);
    link_up = 1'b1;
    push(44, S_PERST, 3);
    push(45, S_PL, 15);  push(45, S_STATE, 4);
    push(46, S_DONE, 1); push(46, S_STATE, 5); push(46, S_RETRY, 0);
    run_to(46);
    flush_check("single_retry");
  endtask

  task automatic test_exhaust();
    apply_reset();
    start_seq();
    push(31, S_RETRY, 1); push(31, S_STATE, 1);
    push(61, S_STATE, 4); push(61, S_FAIL, 0);
    push(62, S_STATE, 6); push(62, S_FAIL, 1); push(62, S_RETRY, 2);
    push(62, S_POR, 0);   push(62, S_CPM, 0);  push(62, S_PERST, 0); push(62, S_PL, 0);
    push(70, S_STATE, 6); push(70, S_FAIL, 1);
    run_to(70);
    flush_check("exhaust");
    start_seq();
    n_vec++;
    if ({fail, retry_cnt, state_o} !== {1'b0, 2'd0, 3'd1}) begin
      n_bad++;
      $display("FAIL restart_from_fail: got fail=%b retry=%0d st=%0d expected fail=0 retry=0 st=1",
               fail, retry_cnt, state_o);
    end
    push(8, S_POR, 0);
    push(9, S_POR, 1); push(9, S_STATE, 2);
    run_to(9);
    flush_check("restart");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start_seq();
    push(11, S_STATE, 2); push(11, S_POR, 1);
    run_to(11);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_all_reset("reset_mid_sequence");
    @(negedge clk);
    sys_rst_n = 1'b1;
    flush_check("reset_mid");
  endtask

  task automatic test_ignored_start();
    apply_reset();
    start_seq();
    run_to(20);
    start = 1'b1;
    push(21, S_STATE, 4);
    step();
    start = 1'b0;
    push(30, S_STATE, 4); push(30, S_RETRY, 0);
    push(31, S_STATE, 1); push(31, S_RETRY, 1); push(31, S_POR, 0);
    run_to(31);
    flush_check("ignored_start");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_linkdown();
    test_single_retry();
    test_exhaust();
    test_reset_mid();
    test_ignored_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
